// File: rtl/tt_uart_tx.sv
// Byte-wide UART transmitter: valid/ready byte input, 8N1 serial output on a registered pin.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module tt_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          tx_q;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  assign tx_ready = (state == IDLE) & ena & ~rst;
  assign busy     = (state != IDLE);
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx_q  <= 1'b1;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (tx_valid && tx_ready) begin
            shreg <= tx_data;
            cnt   <= '0;
            idx   <= '0;
            tx_q  <= 1'b0;
            state <= START;
`ifdef UART_TX_PARITY_EN
            par   <= ^tx_data;
`endif
          end
        end
        START: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            tx_q  <= shreg[0];
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q  <= par;
              state <= PARITY;
`else
              tx_q  <= 1'b1;
              state <= STOP;
`endif
            end else begin
              // tx is registered, so load the next bit from the pre-shift value
              tx_q <= shreg[1];
              idx  <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            tx_q  <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            tx_q  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/tt_uart_tx.md
# tt_uart_tx

Byte-wide UART transmitter that sits directly downstream of the project core inside the `tt_um_Willow240_test` top level. It accepts bytes from the core over a valid/ready handshake and serialises them onto one dedicated output pin (`uo_out[0]` at the top level) as 8N1 frames, with an optional parity bit. The bit period is a fixed number of `clk` cycles.

## Interface
- `CLKS_PER_BIT`, default 16: `clk` cycles per serial bit; legal range 2..65535.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset; the top level drives `rst = ~rst_n`.
- `ena`  in  1  design enable from the TT harness; gates acceptance of new bytes.
- `tx_data`  in  8  byte to send; sampled only on the accepting edge.
- `tx_valid`  in  1  core has a byte on `tx_data`.
- `tx_ready`  out  1  block can accept a byte this cycle.
- `tx`  out  1  serial line; idle level 1.
- `busy`  out  1  a frame is in progress (any state other than IDLE).

## Operation
- States: IDLE, START, DATA, PARITY (only with `UART_TX_PARITY_EN`), STOP.
- `tx_ready = (state == IDLE) & ena & ~rst`. This is combinational from registered state.
- Accept: on an edge where `tx_valid & tx_ready`, latch `tx_data` into the shift register, clear the bit-cycle counter and the bit index, and go to START.
- START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: send 8 bits, LSB first. Each bit lasts `CLKS_PER_BIT` cycles, and the shift register shifts right at each bit boundary. After bit 7, go to PARITY, or to STOP when parity is compiled out.
- PARITY: `tx` = even parity, i.e. the XOR of the 8 latched bits, for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: `tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- IDLE: `tx` = 1.
- `tx` is driven from a register, so the pin has no combinational glitches.
- `tx_data` and `tx_valid` are ignored while `busy`. A changing `tx_data` mid-frame has no effect.
- `ena` falling mid-frame does not abort the frame. The frame completes, and no new byte is accepted while `ena` = 0.
- The bit-cycle counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
- The bit index is 3 bits and counts 0..7.

## Timing
- Reset values: state IDLE, `tx` = 1, `busy` = 0, `tx_ready` = 0 while `rst` = 1. Counters and the shift register are 0.
- Reset mid-frame: on the next edge with `rst` = 1, `tx` returns to 1 and the state to IDLE. No partial stop bit is emitted.
- Accept latency: accepting edge E0 → `tx` = 0 and `busy` = 1 from E0 onward (visible in the cycle after E0).
- Frame length: 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- At the edge ending the stop bit, state becomes IDLE and `busy` = 0. `tx_ready` rises in that same cycle.
- Back-to-back: with `tx_valid` held high, the next start bit begins one cycle after the stop bit ends. One idle cycle at `tx` = 1 separates frames, giving a period of 10·N+1 cycles (11·N+1 with parity).
- Handshake rules:
  - The core must hold `tx_valid` and `tx_data` stable until the handshake occurs.
  - Simultaneous `tx_valid` rise and `ena` rise: the byte is accepted on that edge.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. Frames are start + 8 data + even parity + stop, i.e. 11 bits.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic. Frames are 8N1, i.e. 10 bits.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.
- Reset: hold `rst` = 1 for 3 cycles → `tx` = 1, `busy` = 0, `tx_ready` = 0. After release with `ena` = 1 → `tx_ready` = 1 the next cycle.
- Single byte 0xA5, no parity: sampling `tx` every 4 cycles gives 0,1,0,1,0,0,1,0,1,1. `busy` is high for exactly 40 cycles.
- Single byte 0xA5 with `UART_TX_PARITY_EN`: bits are 0,1,0,1,0,0,1,0,1,**0**,1 (even parity of four 1s is 0). Byte 0x01 gives a parity bit of 1. `busy` is high for 44 cycles.
- Back-to-back: `tx_valid` held high with bytes 0x00 then 0xFF → consecutive start edges 41 cycles apart. `tx_data` changed mid-frame does not corrupt the first frame.
- `ena` gating: drop `ena` during bit 3 of 0x3C → the frame completes correctly. With `tx_valid` = 1 and `ena` = 0, no new start bit appears. The next frame starts 1 cycle after `ena` returns to 1.
- Reset mid-frame: assert `rst` during data bit 5 → `tx` = 1 and `busy` = 0 one edge later. A following 0x81 is sent intact.
